uart_tx_serializer: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_tx_serializer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit state encoding
// Contents:
//   DFIFO_WIDTH               data width of the downstream FIFO
//   DEFAULT_BIT_LENGTH_WIDTH  default width of the clocks-per-bit control
//   uart_tx_state_t           transmit serializer states
package uart_pkg;

   localparam int DFIFO_WIDTH              = 8;
   localparam int DEFAULT_BIT_LENGTH_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable bit-time down-counter with boundary strobe
// Ports:
//   i_clk, i_rst      core clock, synchronous active-high reset
//   i_load            load i_length_m1 into the counter
//   i_run             count down; reload from i_length_m1 after reaching zero
//   i_length_m1       clocks per bit minus one
//   o_tick            high on the last clock of each bit while running
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int WIDTH = DEFAULT_BIT_LENGTH_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_run,
   input  logic [WIDTH-1:0] i_length_m1,
   output logic             o_tick
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= '0;
      end else if (i_load || (i_run && count_q == '0)) begin
         count_q <= i_length_m1;
      end else if (i_run) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign o_tick = i_run && (count_q == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer fed from the DFIFO
// Optional feature macro: UART_TX_PARITY_EN (parity bit generation)
// Ports:
//   i_clk, i_rst             core clock, synchronous active-high reset
//   i_tx_en                  transmit enable
//   i_bit_length             clocks per bit (0 behaves as 1)
//   i_stop_bits              0: one stop bit, 1: two stop bits
//   i_parity_en/i_parity_odd parity enable and type (parity build only)
//   i_dfifo_empty/i_dfifo_data  DFIFO status and read data (one clock after pop)
//   o_dfifo_read_req         single-cycle DFIFO pop
//   o_uart_tx                registered serial line, idle high
//   o_tx_status              frame in flight
//   o_tx_done                pulse on the last clock of the final stop bit
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int BIT_LENGTH_WIDTH = DEFAULT_BIT_LENGTH_WIDTH,
   parameter int DATA_WIDTH       = DFIFO_WIDTH
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_tx_en,
   input  logic [BIT_LENGTH_WIDTH-1:0] i_bit_length,
   input  logic                        i_stop_bits,
   input  logic                        i_parity_en,
   input  logic                        i_parity_odd,
   input  logic                        i_dfifo_empty,
   input  logic [DATA_WIDTH-1:0]       i_dfifo_data,
   output logic                        o_dfifo_read_req,
   output logic                        o_uart_tx,
   output logic                        o_tx_status,
   output logic                        o_tx_done
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   uart_tx_state_t              state_q, state_d;
   logic [DATA_WIDTH-1:0]       data_q;
   logic [IDX_W-1:0]            bit_idx_q, bit_idx_d;
   logic [BIT_LENGTH_WIDTH-1:0] len_m1_q, fetch_len_m1, timer_len_m1;
   logic                        stop2_q, stop_second_q;
   logic                        tick, go, last_bit, frame_end, tx_d, tx_q;

   // A pop is only ever requested with data available and never during reset.
   assign go           = i_tx_en && !i_dfifo_empty && !i_rst;
   assign fetch_len_m1 = (i_bit_length == '0) ? '0 : i_bit_length - BIT_LENGTH_WIDTH'(1);
   assign timer_len_m1 = (state_q == ST_FETCH) ? fetch_len_m1 : len_m1_q;
   assign last_bit     = (bit_idx_q == IDX_W'(DATA_WIDTH - 1));
   assign frame_end    = (state_q == ST_STOP) && tick && (!stop2_q || stop_second_q);

   uart_bit_timer #(.WIDTH(BIT_LENGTH_WIDTH)) u_bit_timer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (state_q == ST_FETCH),
      .i_run       (state_q != ST_IDLE && state_q != ST_FETCH),
      .i_length_m1 (timer_len_m1),
      .o_tick      (tick)
   );

`ifdef UART_TX_PARITY_EN
   logic par_en_q, par_odd_q, parity_bit;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
      end else if (state_q == ST_FETCH) begin
         par_en_q  <= i_parity_en;
         par_odd_q <= i_parity_odd;
      end
   end

   assign parity_bit = (^data_q) ^ par_odd_q;
`else
   logic unused_parity;
   assign unused_parity = i_parity_en ^ i_parity_odd;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (go) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_START;
         ST_START: if (tick) state_d = ST_DATA;
         ST_DATA: begin
            if (tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
               state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (tick) state_d = ST_STOP;
`endif
         ST_STOP:  if (frame_end) state_d = go ? ST_FETCH : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bit_idx_d = bit_idx_q;
      if (state_q == ST_START)              bit_idx_d = '0;
      else if (state_q == ST_DATA && tick)  bit_idx_d = bit_idx_q + IDX_W'(1);
   end

   // The line is registered, so its next value follows the next state.
   always_comb begin
      o_dfifo_read_req = go && (state_q == ST_IDLE || frame_end);
      o_tx_done        = frame_end;
      o_tx_status      = (state_q != ST_IDLE);
      tx_d             = 1'b1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = data_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = parity_bit;
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_q          <= 1'b1;
         data_q        <= '0;
         bit_idx_q     <= '0;
         len_m1_q      <= '0;
         stop2_q       <= 1'b0;
         stop_second_q <= 1'b0;
      end else begin
         tx_q      <= tx_d;
         bit_idx_q <= bit_idx_d;
         if (state_q == ST_FETCH) begin
            data_q   <= i_dfifo_data;
            len_m1_q <= fetch_len_m1;
            stop2_q  <= i_stop_bits;
         end
         // Toggles high after the first of two stop bits, clears at frame end.
         if (state_q == ST_STOP && tick) stop_second_q <= stop2_q && !stop_second_q;
      end
   end

   assign o_uart_tx = tx_q;

endmodule
